// File: rtl/cic_interp_integrator_pkg.sv
// Shared CIC definitions: ratio/stage defaults used by both the comb chain and
// the integrator half, plus the accumulator width rule.
package cic_pkg;

    localparam int CIC_R_DEFAULT = 8;
    localparam int CIC_N_DEFAULT = 3;

    // Phase counter for the default ratio; a filter built with another R
    // derives its own counter width from that R.
    typedef logic [$clog2(CIC_R_DEFAULT)-1:0] cic_phase_t;

    // Bit growth of an N-stage, ratio-R CIC is N*log2(R) on top of the input.
    function automatic int cic_acc_width(input int in_w, input int n, input int r);
        return in_w + n * $clog2(r);
    endfunction

endpackage

// File: rtl/cic_interp_integrator_if.sv
// Low-rate sample handshake in, high-rate sample stream out, for the CIC
// interpolation integrator section.
interface cic_interp_integrator_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24
);
    logic                    ena;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    underrun;

    modport master (
        output ena, in_data, in_valid,
        input  in_ready, out_data, out_valid, underrun
    );

    modport slave (
        input  ena, in_data, in_valid,
        output in_ready, out_data, out_valid, underrun
    );
endinterface

// File: rtl/cic_interp_integrator_integrator.sv
// One CIC integrator stage: modular ACC_W accumulator advanced on ena.
module cic_integrator #(
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic signed [ACC_W-1:0] din,
    output logic signed [ACC_W-1:0] acc
);

    // NOTE: state registers use non-blocking assignment so every stage samples
    // its neighbour's previous-cycle value, which is what the cascade requires.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (ena) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/cic_interp_integrator.sv
// CIC interpolator back half: one-entry input buffer, zero-stuffing by R,
// N integrators, truncated output. Define CIC_INTERP_ROUND_EN for half-up rounding.
module cic_interp_integrator
    import cic_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter int R     = CIC_R_DEFAULT,
    parameter int N     = CIC_N_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    cic_interp_integrator_if.slave   bus
);

    localparam int ACC_W = cic_acc_width(IN_W, N, R);
    localparam int PH_W  = $clog2(R);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

    logic [PH_W-1:0]         phase;
    logic signed [IN_W-1:0]  buf_data;
    logic                    buf_full;
    logic                    underrun_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_valid_q;

    logic signed [ACC_W-1:0] inject;
    logic signed [ACC_W-1:0] stage_in [N];
    logic signed [ACC_W-1:0] acc      [N];
    logic signed [ACC_W-1:0] last_nxt;
    logic signed [OUT_W-1:0] out_nxt;

    // Only phase 0 carries a real sample; every other phase is a stuffed zero.
    always_comb begin
        inject = '0;
        if (phase == '0 && buf_full) begin
            inject = ACC_W'(buf_data);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k] = inject;
        end else begin : g_chain
            assign stage_in[k] = acc[k-1];
        end

        cic_integrator #(.ACC_W(ACC_W)) u_int (
            .clk (clk),
            .rst (rst),
            .ena (bus.ena),
            .din (stage_in[k]),
            .acc (acc[k])
        );
    end

    // The output register takes the value the last stage is about to hold,
    // so out_data reflects this tick's update one clk later alongside out_valid.
    assign last_nxt = acc[N-1] + stage_in[N-1];

    if (OUT_W >= ACC_W) begin : g_sext
        assign out_nxt = OUT_W'(last_nxt);
    end else begin : g_trunc
        logic signed [ACC_W-1:0] rounded;
`ifdef CIC_INTERP_ROUND_EN
        localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (ACC_W - OUT_W - 1);
        assign rounded = last_nxt + HALF;
`else
        assign rounded = last_nxt;
`endif
        assign out_nxt = OUT_W'(rounded >>> (ACC_W - OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            underrun_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.ena;

            // A load and a consume never coincide: loads need buf_full low.
            if (bus.in_valid && !buf_full) begin
                buf_data <= bus.in_data;
                buf_full <= 1'b1;
            end

            if (bus.ena) begin
                phase      <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                out_data_q <= out_nxt;
                if (phase == '0) begin
                    if (buf_full) begin
                        buf_full <= 1'b0;
                    end else begin
                        underrun_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = !buf_full;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_cic_interp_integrator.sv
// Directed scoreboard bench for cic_interp_integrator across four parameter
// sets (ramp, zero-stuff/underrun/reset, wrap with sign-extension, rounding).
module tb_cic_interp_integrator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // a: N=2 R=4 ACC=20 OUT=20 | b: N=1 R=4 ACC=18 OUT=18
    // c: IN=4 N=1 R=2 ACC=5 OUT=8 | d: N=1 R=4 ACC=18 OUT=16
    cic_interp_integrator_if #(.IN_W(16), .OUT_W(20)) if_a ();
    cic_interp_integrator_if #(.IN_W(16), .OUT_W(18)) if_b ();
    cic_interp_integrator_if #(.IN_W(4),  .OUT_W(8))  if_c ();
    cic_interp_integrator_if #(.IN_W(16), .OUT_W(16)) if_d ();

    cic_interp_integrator #(.IN_W(16), .OUT_W(20), .R(4), .N(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    cic_interp_integrator #(.IN_W(16), .OUT_W(18), .R(4), .N(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    cic_interp_integrator #(.IN_W(4),  .OUT_W(8),  .R(2), .N(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
    cic_interp_integrator #(.IN_W(16), .OUT_W(16), .R(4), .N(1)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

    localparam int A = 0, B = 1, C = 2, D = 3;

    int checks = 0;
    int errors = 0;
    logic signed [63:0] exp_q [$];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ena(input int sel, input logic v);
        case (sel)
            A:       if_a.ena = v;
            B:       if_b.ena = v;
            C:       if_c.ena = v;
            default: if_d.ena = v;
        endcase
    endtask

    task automatic set_in(input int sel, input logic v, input logic signed [15:0] d);
        case (sel)
            A:       begin if_a.in_valid = v; if_a.in_data = d; end
            B:       begin if_b.in_valid = v; if_b.in_data = d; end
            C:       begin if_c.in_valid = v; if_c.in_data = d[3:0]; end
            default: begin if_d.in_valid = v; if_d.in_data = d; end
        endcase
    endtask

    function automatic logic signed [63:0] obs_data(input int sel);
        case (sel)
            A:       return 64'(if_a.out_data);
            B:       return 64'(if_b.out_data);
            C:       return 64'(if_c.out_data);
            default: return 64'(if_d.out_data);
        endcase
    endfunction

    function automatic logic obs_valid(input int sel);
        case (sel)
            A:       return if_a.out_valid;
            B:       return if_b.out_valid;
            C:       return if_c.out_valid;
            default: return if_d.out_valid;
        endcase
    endfunction

    function automatic logic obs_ready(input int sel);
        case (sel)
            A:       return if_a.in_ready;
            B:       return if_b.in_ready;
            C:       return if_c.in_ready;
            default: return if_d.in_ready;
        endcase
    endfunction

    function automatic logic obs_under(input int sel);
        case (sel)
            A:       return if_a.underrun;
            B:       return if_b.underrun;
            C:       return if_c.underrun;
            default: return if_d.underrun;
        endcase
    endfunction

    // Offer one sample; in_ready must be high before and low after the transfer.
    task automatic load(input int sel, input logic signed [15:0] d, input string tag);
        @(negedge clk);
        check({tag, "_rdy_pre"}, 64'(obs_ready(sel)), 64'd1);
        set_in(sel, 1'b1, d);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 16'sd0);
        check({tag, "_rdy_post"}, 64'(obs_ready(sel)), 64'd0);
    endtask

    // One ena pulse; the expected sample is queued at drive time and popped
    // when out_valid is due.
    task automatic tick(input int sel, input logic signed [63:0] exp, input string tag);
        @(negedge clk);
        set_ena(sel, 1'b1);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        set_ena(sel, 1'b0);
        check({tag, "_valid"}, 64'(obs_valid(sel)), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            check(tag, obs_data(sel), exp_q.pop_front());
        end
    endtask

    // A clk without ena: out_valid must drop and out_data must hold.
    task automatic idle_chk(input int sel, input logic signed [63:0] hold, input string tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        check({tag, "_valid_low"}, 64'(obs_valid(sel)), 64'd0);
        check({tag, "_hold"}, obs_data(sel), hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            set_ena(s, 1'b0);
            set_in(s, 1'b0, 16'sd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rst%0d_data", s),  obs_data(s),         64'sd0);
            check($sformatf("rst%0d_valid", s), 64'(obs_valid(s)),   64'd0);
            check($sformatf("rst%0d_ready", s), 64'(obs_ready(s)),   64'd1);
            check($sformatf("rst%0d_under", s), 64'(obs_under(s)),   64'd0);
        end

        // Impulse into N=2: second integrator ramps 0,1,2,...
        load(A, 16'sd1, "a_load");
        for (int i = 0; i < 12; i++) begin
            tick(A, 64'(i), $sformatf("a_ramp%0d", i));
            if (i == 2) idle_chk(A, 64'sd2, "a_gap");
        end

        // Zero-stuffing with N=1: each sample held for R ticks, accumulating.
        load(B, 16'sd5, "b_load5");
        tick(B, 64'sd5, "b_t0");
        check("b_rdy_rise", 64'(obs_ready(B)), 64'd1);
        load(B, 16'sd3, "b_load3");
        for (int i = 1; i < 4; i++) tick(B, 64'sd5, $sformatf("b_t%0d", i));
        tick(B, 64'sd8, "b_t4");
        check("b_rdy_rise2", 64'(obs_ready(B)), 64'd1);
        for (int i = 5; i < 8; i++) tick(B, 64'sd8, $sformatf("b_t%0d", i));
        check("b_no_under", 64'(obs_under(B)), 64'd0);

        // Phase-0 tick with nothing buffered: zero injected, underrun sticks.
        tick(B, 64'sd8, "b_under_t8");
        check("b_under_set", 64'(obs_under(B)), 64'd1);
        for (int i = 9; i < 12; i++) tick(B, 64'sd8, $sformatf("b_t%0d", i));
        load(B, 16'sd2, "b_load2");
        tick(B, 64'sd10, "b_t12");
        check("b_under_sticky", 64'(obs_under(B)), 64'd1);

        // Reset mid-stream with a pending sample while ena/in_valid are high.
        load(B, 16'sd4, "b_load4");
        @(negedge clk);
        rst = 1'b1;
        set_ena(B, 1'b1);
        set_in(B, 1'b1, 16'sd9);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ena(B, 1'b0);
        set_in(B, 1'b0, 16'sd0);
        check("b_mrst_data",  obs_data(B),         64'sd0);
        check("b_mrst_valid", 64'(obs_valid(B)),   64'd0);
        check("b_mrst_under", 64'(obs_under(B)),   64'd0);
        check("b_mrst_ready", 64'(obs_ready(B)),   64'd1);
        load(B, 16'sd6, "b_load6");
        tick(B, 64'sd6, "b_r0");
        for (int i = 1; i < 4; i++) tick(B, 64'sd6, $sformatf("b_r%0d", i));
        check("b_r_no_under", 64'(obs_under(B)), 64'd0);
        tick(B, 64'sd6, "b_r4");
        check("b_r_under", 64'(obs_under(B)), 64'd1);

        // Wrap in a 5-bit accumulator, sign-extended onto an 8-bit output.
        load(C, 16'sd7, "c_load0");
        tick(C, 64'sd7, "c_t0");
        tick(C, 64'sd7, "c_t1");
        load(C, 16'sd7, "c_load1");
        tick(C, 64'sd14, "c_t2");
        tick(C, 64'sd14, "c_t3");
        load(C, 16'sd7, "c_load2");
        tick(C, -64'sd11, "c_t4_wrap");
        tick(C, -64'sd11, "c_t5");
        load(C, 16'sd7, "c_load3");
        tick(C, -64'sd4, "c_t6");

        // Output two bits narrower than the accumulator: truncate or round.
`ifdef CIC_INTERP_ROUND_EN
        load(D, 16'sd6, "d_load6");
        for (int i = 0; i < 4; i++) tick(D, 64'sd2, $sformatf("d_acc6_%0d", i));
        load(D, -16'sd3, "d_loadm3");
        tick(D, 64'sd1, "d_acc3");
        for (int i = 1; i < 4; i++) tick(D, 64'sd1, $sformatf("d_acc3_%0d", i));
        load(D, -16'sd4, "d_loadm4");
        tick(D, 64'sd0, "d_accm1");
`else
        load(D, 16'sd6, "d_load6");
        for (int i = 0; i < 4; i++) tick(D, 64'sd1, $sformatf("d_acc6_%0d", i));
        load(D, -16'sd3, "d_loadm3");
        tick(D, 64'sd0, "d_acc3");
        for (int i = 1; i < 4; i++) tick(D, 64'sd0, $sformatf("d_acc3_%0d", i));
        load(D, -16'sd4, "d_loadm4");
        tick(D, -64'sd1, "d_accm1");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
